// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline definitions for the stall controller and its HI/LO busy timer.
package stall_ctrl_pkg;

  // Default latencies of the HI/LO unit, in cycles.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Operand-use / result-ready timing field widths.
  localparam int TUSE_W = 2;
  localparam int TNEW_W = 3;

  // Tuse code meaning "this operand is not read".
  localparam logic [TUSE_W-1:0] TUSE_UNUSED = 2'd3;

  // HI/LO timer states.
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Down-counter width: wide enough for the longest operation, never below 4 bits.
  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    int mx;
    int w;
    mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    w  = $clog2(mx + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_timer.sv
// HI/LO unit busy timer: counts down the latency of a mult/div started in E.
// A start seen while already busy is ignored so the running operation is not disturbed.
module md_busy_timer
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic start_div,
  output logic md_busy,
  output logic md_done
);

  localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  assign load_val = start_div ? DIV_LOAD : MULT_LOAD;

  // Timer FSM; md_busy/md_done are registered alongside the state so they
  // always equal (state==BUSY) and (state==BUSY && cnt==1).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state   <= MD_BUSY;
            cnt     <= load_val;
            md_busy <= 1'b1;
            md_done <= (load_val == CNT_ONE);
          end else begin
            state   <= MD_IDLE;
            cnt     <= cnt;
            md_busy <= 1'b0;
            md_done <= 1'b0;
          end
        end
        MD_BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= MD_IDLE;
            md_busy <= 1'b0;
            md_done <= 1'b0;
          end else begin
            state   <= MD_BUSY;
            md_busy <= 1'b1;
            md_done <= (cnt == CNT_TWO);
          end
        end
        default: begin
          state   <= MD_IDLE;
          cnt     <= '0;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: detects RAW hazards on the D-stage sources and
// HI/LO conflicts, freezes F/D and bubbles D->E, and counts stalled cycles.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             D_rs_addr,
  input  logic [4:0]             D_rt_addr,
  input  logic [TUSE_W-1:0]      D_Tuse_rs,
  input  logic [TUSE_W-1:0]      D_Tuse_rt,
  input  logic                   D_is_md,
  input  logic [4:0]             E_wa,
  input  logic [4:0]             M_wa,
  input  logic [TNEW_W-1:0]      E_Tnew,
  input  logic [TNEW_W-1:0]      M_Tnew,
  input  logic                   E_md_start,
  input  logic                   E_md_div,
  output logic                   F_en,
  output logic                   FD_en,
  output logic                   DE_clr,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [TNEW_W-1:0] tuse_rs_ext;
  logic [TNEW_W-1:0] tuse_rt_ext;
  logic              rs_haz;
  logic              rt_haz;
  logic              md_haz;
  logic              stall;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (E_md_start),
    .start_div (E_md_div),
    .md_busy   (md_busy),
    .md_done   (md_done)
  );

  assign tuse_rs_ext = {{(TNEW_W-TUSE_W){1'b0}}, D_Tuse_rs};
  assign tuse_rt_ext = {{(TNEW_W-TUSE_W){1'b0}}, D_Tuse_rt};

  // Hazard detection; register 0 is hard-wired so it never needs forwarding.
  always_comb begin
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    if (D_rs_addr != 5'd0) begin
      rs_haz = ((E_wa == D_rs_addr) && (E_Tnew > tuse_rs_ext)) ||
               ((M_wa == D_rs_addr) && (M_Tnew > tuse_rs_ext));
    end else begin
      rs_haz = 1'b0;
    end
    if (D_rt_addr != 5'd0) begin
      rt_haz = ((E_wa == D_rt_addr) && (E_Tnew > tuse_rt_ext)) ||
               ((M_wa == D_rt_addr) && (M_Tnew > tuse_rt_ext));
    end else begin
      rt_haz = 1'b0;
    end
  end

  assign md_haz = D_is_md && (md_busy || E_md_start);
  assign stall  = rs_haz || rt_haz || md_haz;
  assign F_en   = !stall;
  assign FD_en  = !stall;
  assign DE_clr = stall;

  // Saturating stalled-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl with default parameters.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt;
  logic        D_is_md;
  logic [4:0]  E_wa, M_wa;
  logic [2:0]  E_Tnew, M_Tnew;
  logic        E_md_start, E_md_div;
  logic        F_en, FD_en, DE_clr, md_busy, md_done;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  stall_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_is_md(D_is_md), .E_wa(E_wa), .M_wa(M_wa),
    .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .F_en(F_en), .FD_en(FD_en), .DE_clr(DE_clr),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_rs_addr = 5'd0; D_rt_addr = 5'd0;
    D_Tuse_rs = TUSE_UNUSED; D_Tuse_rt = TUSE_UNUSED;
    D_is_md = 1'b0;
    E_wa = 5'd0; M_wa = 5'd0; E_Tnew = 3'd0; M_Tnew = 3'd0;
    E_md_start = 1'b0; E_md_div = 1'b0;
  endtask

  task automatic chk_stall(input string tag, input logic exp_stall);
    chk({tag, "_F_en"}, {31'd0, F_en}, {31'd0, !exp_stall});
    chk({tag, "_FD_en"}, {31'd0, FD_en}, {31'd0, !exp_stall});
    chk({tag, "_DE_clr"}, {31'd0, DE_clr}, {31'd0, exp_stall});
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk_stall("rst", 1'b0);

    // E-stage RAW hazard on rs: stall, counter +1 per edge
    D_rs_addr = 5'd5; E_wa = 5'd5; E_Tnew = 3'd2; D_Tuse_rs = 2'd0;
    #1;
    chk_stall("rs_e_haz", 1'b1);
    step();
    chk("rs_cnt1", {16'd0, stall_cnt}, 32'd1);
    step();
    chk("rs_cnt2", {16'd0, stall_cnt}, 32'd2);
    idle_inputs();
    #1;
    chk_stall("clear", 1'b0);
    step();
    chk("cnt_hold", {16'd0, stall_cnt}, 32'd2);

    // Register 0 never hazards, even against wa=0
    D_rt_addr = 5'd0; E_wa = 5'd0; E_Tnew = 3'd2; D_Tuse_rt = 2'd0;
    M_wa = 5'd0; M_Tnew = 3'd7; D_Tuse_rs = 2'd0;
    #1;
    chk_stall("zero_reg", 1'b0);

    // M-stage hazard on rt and Tnew/Tuse boundaries
    idle_inputs();
    D_rt_addr = 5'd7; M_wa = 5'd7; M_Tnew = 3'd2; D_Tuse_rt = 2'd1;
    #1;
    chk_stall("rt_m_haz", 1'b1);
    M_Tnew = 3'd1;
    #1;
    chk_stall("rt_m_equal", 1'b0);
    idle_inputs();
    D_rs_addr = 5'd9; E_wa = 5'd9; E_Tnew = 3'd3; D_Tuse_rs = TUSE_UNUSED;
    #1;
    chk_stall("tuse3_eq", 1'b0);
    E_Tnew = 3'd4;
    #1;
    chk_stall("tuse3_gt", 1'b1);
    E_wa = 5'd10;
    #1;
    chk_stall("addr_miss", 1'b0);
    idle_inputs();
    #1;

    // Mult at T with D_is_md held: stall T..T+5, busy T+1..T+5, done T+5
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b0;
    #1;
    chk_stall("mult_T", 1'b1);
    chk("mult_T_busy", {31'd0, md_busy}, 32'd0);
    step();
    E_md_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("mult_busy_%0d", k), {31'd0, md_busy}, 32'd1);
      chk($sformatf("mult_done_%0d", k), {31'd0, md_done}, {31'd0, (k == 5)});
      chk_stall($sformatf("mult_stall_%0d", k), 1'b1);
      step();
    end
    #1;
    chk("mult_end_busy", {31'd0, md_busy}, 32'd0);
    chk("mult_end_done", {31'd0, md_done}, 32'd0);
    chk_stall("mult_end", 1'b0);
    chk("mult_cnt", {16'd0, stall_cnt}, 32'd8);
    D_is_md = 1'b0;

    // Div at T, extra start at T+3 ignored: busy T+1..T+10, done only T+10
    E_md_start = 1'b1; E_md_div = 1'b1;
    step();
    E_md_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      E_md_start = (k == 3);
      E_md_div = 1'b0;
      #1;
      chk($sformatf("div_busy_%0d", k), {31'd0, md_busy}, 32'd1);
      chk($sformatf("div_done_%0d", k), {31'd0, md_done}, {31'd0, (k == 10)});
      step();
    end
    E_md_start = 1'b0;
    #1;
    chk("div_end_busy", {31'd0, md_busy}, 32'd0);
    chk("div_cnt", {16'd0, stall_cnt}, 32'd8);

    // Reset at T+4 of a div, with a stall and a start pending
    E_md_start = 1'b1; E_md_div = 1'b1;
    step();
    E_md_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("rdiv_busy_%0d", k), {31'd0, md_busy}, 32'd1);
      step();
    end
    reset = 1'b1; D_is_md = 1'b1; E_md_start = 1'b1;
    #1;
    chk_stall("rdiv_T4", 1'b1);
    step();
    reset = 1'b0; D_is_md = 1'b0; E_md_start = 1'b0;
    #1;
    chk("rdiv_busy_after", {31'd0, md_busy}, 32'd0);
    chk("rdiv_done_after", {31'd0, md_done}, 32'd0);
    chk("rdiv_cnt_after", {16'd0, stall_cnt}, 32'd0);
    chk_stall("rdiv_after", 1'b0);

    // Fresh mult after reset
    E_md_start = 1'b1; E_md_div = 1'b0;
    step();
    E_md_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("pm_busy_%0d", k), {31'd0, md_busy}, 32'd1);
      chk($sformatf("pm_done_%0d", k), {31'd0, md_done}, {31'd0, (k == 5)});
      step();
    end
    #1;
    chk("pm_end_busy", {31'd0, md_busy}, 32'd0);
    chk("pm_cnt", {16'd0, stall_cnt}, 32'd0);

    // Saturation: hold a stall for 2^16+3 edges
    D_rs_addr = 5'd5; E_wa = 5'd5; E_Tnew = 3'd2; D_Tuse_rs = 2'd0;
    repeat (65534) step();
    chk("sat_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
    step();
    chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
    repeat (4) step();
    chk("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk_stall("sat", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
